// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard encoder: FSM states, scan-set-2
// prefix bytes and the device-response bytes that never produce a key event.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam int N_RESP = 7;
   localparam logic [7:0] PS2_RESP [N_RESP] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

   function automatic logic is_response(input logic [7:0] b);
      is_response = 1'b0;
      for (int i = 0; i < N_RESP; i++) begin
         if (b == PS2_RESP[i]) is_response = 1'b1;
      end
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, debounces ps2_clk and emits a one-cycle fall pulse.
// Latency 2 sync + FILTER_LEN cycles from raw edge to fall; no backpressure.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data_sync
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_meta;
   logic [1:0]    dat_meta;
   logic          clk_filt;
   logic [CW-1:0] flt_cnt;

   assign data_sync = dat_meta[1];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta <= 2'b11;
         dat_meta <= 2'b11;
         clk_filt <= 1'b1;
         flt_cnt  <= '0;
         fall     <= 1'b0;
      end else begin
         clk_meta <= {clk_meta[0], ps2_clk};
         dat_meta <= {dat_meta[0], ps2_data};
         fall     <= 1'b0;
         // The filtered clock only follows after FILTER_LEN consecutive disagreeing samples.
         if (clk_meta[1] == clk_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_meta[1];
            flt_cnt  <= '0;
            fall     <= clk_filt;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 frame receiver folding scan-set-2 prefixes into one toggled ps2_key event per key.
// Event one cycle after the stop-bit fall; no backpressure (events are a frame apart).
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_strobe,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic          fall;
   logic          din;
   ps2_state_t    st;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_ok;
   logic [TW-1:0] tmo_cnt;
   logic          rel;
   logic          ext;
   logic [2:0]    skip;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_line (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .fall      (fall),
      .data_sync (din)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         st         <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_ok     <= 1'b0;
         tmo_cnt    <= '0;
         rel        <= 1'b0;
         ext        <= 1'b0;
         skip       <= '0;
         ps2_key    <= '0;
         key_strobe <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         frame_err  <= 1'b0;
         if (st == IDLE) begin
            tmo_cnt <= '0;
            if (fall) begin
               if (!din) begin
                  st      <= DATA;
                  bit_cnt <= '0;
               end else begin
                  frame_err <= 1'b1;
                  rel       <= 1'b0;
                  ext       <= 1'b0;
                  skip      <= '0;
               end
            end
         end else if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
            st        <= IDLE;
            tmo_cnt   <= '0;
            frame_err <= 1'b1;
            rel       <= 1'b0;
            ext       <= 1'b0;
            skip      <= '0;
         end else if (!fall) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
            case (st)
               DATA: begin
                  shreg   <= {din, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) st <= PARITY;
               end
               PARITY: begin
                  par_ok <= ^{shreg, din};
                  st     <= STOP;
               end
               default: begin
                  st <= IDLE;
                  if (din && par_ok) begin
                     // Prefixes persist across idle time until an event or an error consumes them.
                     if (skip != 3'd0) begin
                        skip <= skip - 1'b1;
                     end else if (shreg == PS2_PAUSE) begin
                        skip <= PAUSE_SKIP;
                     end else if (shreg == PS2_EXT) begin
                        ext <= 1'b1;
                     end else if (shreg == PS2_REL) begin
                        rel <= 1'b1;
                     end else if (!rel && !ext && is_response(shreg)) begin
                        skip <= '0;
                     end else begin
                        ps2_key    <= {~ps2_key[10], ~rel, ext, shreg};
                        key_strobe <= 1'b1;
                        rel        <= 1'b0;
                        ext        <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     rel       <= 1'b0;
                     ext       <= 1'b0;
                     skip      <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule
